// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand/op request side plus registered result side.
// The master drives operations and consumes results; the slave is the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [2:0]       Op;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             OFL;
  logic             Zero;
  logic             busy;

  modport master (
    output in_valid, A, B, Cin, Op, sign, out_ready,
    input  in_ready, out_valid, Out, OFL, Zero, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, Op, sign, out_ready,
    output in_ready, out_valid, Out, OFL, Zero, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked 8-op ALU with an iterative one-bit-per-cycle shifter and registered result.
// Define ALU_SAT_EN to make ADD saturate on overflow instead of wrapping.
module alu_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               ofl_q, ofl_d;
  logic               zero_q, zero_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         shop_q, shop_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum;
  logic               add_ofl;
  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shifted;

  // HOLD can accept while its result is being taken, giving back-to-back issue.
  assign bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign shamt         = bus.B[SHAMT_W-1:0];

  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state == SHIFT);
  assign bus.Out       = out_q;
  assign bus.OFL       = ofl_q;
  assign bus.Zero      = zero_q;

  always_comb begin
    sum     = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
    add_res = sum[WIDTH-1:0];
    if (bus.sign)
      add_ofl = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
    else
      add_ofl = sum[WIDTH];
`ifdef ALU_SAT_EN
    // Signed overflow direction follows the common operand sign.
    if (add_ofl) begin
      if (bus.sign)
        add_res = bus.A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        add_res = '1;
    end
`endif
  end

  always_comb begin
    unique case (bus.Op[1:0])
      2'd0:    alu_res = add_res;
      2'd1:    alu_res = bus.A | bus.B;
      2'd2:    alu_res = bus.A ^ bus.B;
      default: alu_res = bus.A & bus.B;
    endcase
  end

  always_comb begin
    unique case (shop_q)
      2'd0:    shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      2'd1:    shifted = {out_q[WIDTH-2:0], 1'b0};
      2'd2:    shifted = {out_q[0], out_q[WIDTH-1:1]};
      default: shifted = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
    endcase
  end

  // Out doubles as the shift working register; Zero tracks every value loaded into it.
  always_comb begin
    state_d = state;
    out_d   = out_q;
    ofl_d   = ofl_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    shop_d  = shop_q;

    unique case (state)
      IDLE: ;
      SHIFT: begin
        out_d  = shifted;
        zero_d = (shifted == '0);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1))
          state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready && !bus.in_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (bus.Op[2]) begin
        out_d   = alu_res;
        ofl_d   = (bus.Op == 3'd4) && add_ofl;
        zero_d  = (alu_res == '0);
        state_d = HOLD;
      end else begin
        out_d  = bus.A;
        ofl_d  = 1'b0;
        zero_d = (bus.A == '0);
        cnt_d  = shamt;
        shop_d = bus.Op[1:0];
        state_d = (shamt == '0) ? HOLD : SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out_q  <= '0;
      ofl_q  <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      shop_q <= 2'd0;
    end else begin
      state  <= state_d;
      out_q  <= out_d;
      ofl_q  <= ofl_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
      shop_q <= shop_d;
    end
  end
endmodule
